// File: rtl/cam_ctrl.sv
// cam_ctrl: command sequencer in front of a NB_MEM x DATA_W CAM.
//   Accepts INSERT / LOOKUP / WRITE_AT commands over a valid-ready port,
//   drives the CAM write/enable/addr/data pins, tracks the insert pointer
//   and fill count, and returns one response per command.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/ready/op/addr/data    command port (op 00 INSERT, 01 LOOKUP,
//                                   10 WRITE_AT, 11 reserved)
//   rsp_valid/ready/hit/index/err   response port
//   full, count                     fill status (INSERT entries only)
//   cam_write/enable/addr/data      to CAM
//   cam_out, cam_found              from CAM (out combinational, found registered)
// Configuration:
//   CAM_CTRL_WRAP_EN  when defined, INSERT while full overwrites the oldest
//                     entry instead of being rejected.
module cam_ctrl #(
  parameter int unsigned NB_MEM    = 16,
  parameter int unsigned SIZE_ADDR = 4,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [SIZE_ADDR:0]   cmd_addr,
  input  logic [DATA_W-1:0]    cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [SIZE_ADDR:0]   rsp_index,
  output logic                 rsp_err,
  output logic                 full,
  output logic [SIZE_ADDR:0]   count,
  output logic                 cam_write,
  output logic                 cam_enable,
  output logic [SIZE_ADDR:0]   cam_addr,
  output logic [DATA_W-1:0]    cam_data,
  input  logic [SIZE_ADDR:0]   cam_out,
  input  logic                 cam_found
);

  localparam int unsigned IDX_W = SIZE_ADDR + 1;
  localparam logic [IDX_W-1:0] COUNT_MAX = IDX_W'(NB_MEM);

`ifdef CAM_CTRL_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_INSERT   = 2'b00,
    OP_LOOKUP   = 2'b01,
    OP_WRITE_AT = 2'b10,
    OP_RSVD     = 2'b11
  } op_t;

  state_t                 state;
  op_t                    op_q;
  logic [SIZE_ADDR-1:0]   ptr;
  logic                   cmd_err_c;
  logic [IDX_W-1:0]       count_inc_c;
  logic                   unused_addr_msb;

  // Only the low address bits select a CAM entry.
  assign unused_addr_msb = cmd_addr[IDX_W-1];

  // Commands answered immediately without touching the CAM.
  assign cmd_err_c = (cmd_op == OP_RSVD) ||
                     ((cmd_op == OP_INSERT) && full && !WRAP_EN);

  // Fill count saturates at NB_MEM (only reachable past full with wrap).
  assign count_inc_c = (count == COUNT_MAX) ? count : count + IDX_W'(1);

  // Sequencer: state, bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_INSERT;
      ptr        <= '0;
      count      <= '0;
      full       <= 1'b0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_index  <= '0;
      rsp_err    <= 1'b0;
      cam_write  <= 1'b0;
      cam_enable <= 1'b0;
      cam_addr   <= '0;
      cam_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= op_t'(cmd_op);
            // Key stays on the CAM data pins until the next accept so that
            // cam_out remains stable for the whole command.
            cam_data  <= cmd_data;
            if (cmd_err_c) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_hit   <= 1'b0;
              rsp_index <= '0;
              state     <= RESP;
            end else begin
              state <= EXEC;
              case (op_t'(cmd_op))
                OP_INSERT: begin
                  cam_write <= 1'b1;
                  cam_addr  <= {1'b0, ptr};
                end
                OP_WRITE_AT: begin
                  cam_write <= 1'b1;
                  cam_addr  <= {1'b0, cmd_addr[SIZE_ADDR-1:0]};
                end
                default: begin
                  cam_enable <= 1'b1;
                  cam_addr   <= '0;
                end
              endcase
            end
          end
        end

        EXEC: begin
          cam_write  <= 1'b0;
          cam_enable <= 1'b0;
          rsp_err    <= 1'b0;
          rsp_hit    <= 1'b0;
          case (op_q)
            OP_LOOKUP: begin
              rsp_index <= cam_out;
              state     <= CAPT;
            end
            OP_INSERT: begin
              ptr       <= ptr + SIZE_ADDR'(1);
              count     <= count_inc_c;
              full      <= (count_inc_c == COUNT_MAX);
              rsp_index <= cam_addr;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
            OP_WRITE_AT: begin
              rsp_index <= cam_addr;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
            default: begin
              rsp_index <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          endcase
        end

        // cam_found was registered by the CAM on the enable edge.
        CAPT: begin
          rsp_hit   <= cam_found;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
